// File: rtl/if_pc_fetch.sv
// IF-stage fetch controller: owns the fetch PC, keeps at most one IMEM request
// in flight, and hands instructions to IF/ID while honouring EX redirects.
module if_pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   output logic        misaligned_fault,
   output logic [31:0] fault_pc
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic        drop_q, drop_d;
   logic        fault_q, fault_d;
   logic        req_fire;
   logic        redir_ok;

   // drop_q marks an in-flight response that belongs to a flushed path
   assign imem_req_valid   = (state_q == S_REQ) && !drop_q && !rst;
   assign imem_req_addr    = pc_q;
   assign req_fire         = imem_req_valid && imem_req_ready;
   assign redir_ok         = redirect_valid && (redirect_addr[1:0] == 2'b00);
   assign out_valid        = (state_q == S_OUT);
   assign out_pc           = out_pc_q;
   assign out_instr        = out_instr_q;
   assign misaligned_fault = fault_q;
   assign fault_pc         = fault_pc_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fetch_pc_d  = fetch_pc_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      fault_pc_d  = fault_pc_q;
      drop_d      = drop_q;
      fault_d     = fault_q;

      if (redirect_valid) begin
         if (redir_ok) begin
            pc_d    = redirect_addr;
            fault_d = 1'b0;
            state_d = S_REQ;
         end else begin
            fault_pc_d = redirect_addr;
            fault_d    = 1'b1;
            state_d    = S_FAULT;
         end
         case (state_q)
            S_REQ: begin
               if (req_fire) begin
                  // the request leaving this cycle is already wrong-path
                  drop_d = 1'b1;
                  if (redir_ok) state_d = S_WAIT;
               end else if (imem_resp_valid) begin
                  drop_d = 1'b0;
               end
            end
            S_WAIT:  drop_d = !imem_resp_valid;
            S_FAULT: if (imem_resp_valid) drop_d = 1'b0;
            default: ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (req_fire) begin
                  fetch_pc_d = pc_q;
                  pc_d       = pc_q + PC_STEP;
                  state_d    = S_WAIT;
               end else if (imem_resp_valid) begin
                  drop_d = 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     out_instr_d = imem_resp_data;
                     out_pc_d    = fetch_pc_q;
                     state_d     = S_OUT;
                  end
               end
            end
            S_OUT:   if (out_ready) state_d = S_REQ;
            S_FAULT: if (imem_resp_valid) drop_d = 1'b0;
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         fetch_pc_q  <= 32'h0;
         out_pc_q    <= 32'h0;
         out_instr_q <= 32'h0;
         fault_pc_q  <= 32'h0;
         drop_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fetch_pc_q  <= fetch_pc_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         fault_pc_q  <= fault_pc_d;
         drop_q      <= drop_d;
         fault_q     <= fault_d;
      end
   end

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
- IF-stage program-counter and fetch controller.
- Holds the architectural fetch PC and issues one instruction-memory request at a time.
- Presents fetched instructions to the IF/ID register over a valid/ready handshake.
- Consumes the EX-stage jump target (pc + imm from JAL and the branch ops) as a redirect, which discards wrong-path fetches and flags misaligned targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 32'd4, sequential PC increment.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
redirect_valid  input  1  EX requests a control-flow change this cycle.
redirect_addr  input  32  target PC from EX (jump_addr).
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch address.
imem_req_ready  input  1  IMEM accepts the request this cycle.
imem_resp_valid  input  1  IMEM returns data (one cycle pulse per accepted request).
imem_resp_data  input  32  instruction word.
out_valid  output  1  instruction available to IF/ID.
out_pc  output  32  PC of the presented instruction.
out_instr  output  32  presented instruction.
out_ready  input  1  IF/ID consumes this cycle.
misaligned_fault  output  1  redirect target not word-aligned.
fault_pc  output  32  offending target.

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, state=REQ, drop=0.
  - All outputs 0, except imem_req_addr=pc.
  - imem_req_valid=0 while rst is high.
- States: REQ, WAIT, OUT, FAULT. At most one IMEM request is outstanding.
- REQ:
  - imem_req_valid = (drop==0); imem_req_addr = pc.
  - On valid & ready: fetch_pc<=pc, pc<=pc+PC_STEP (mod 2^32), go to WAIT.
  - While drop==1: no request; an imem_resp_valid clears drop.
- WAIT:
  - On imem_resp_valid with drop==1: clear drop, go to REQ, no output.
  - Otherwise: out_instr<=data, out_pc<=fetch_pc, go to OUT.
- OUT:
  - out_valid=1; out_pc and out_instr stay stable until out_ready.
  - On out_ready: go to REQ.
  - Minimum spacing is 3 cycles per instruction when IMEM latency is 1.
- Redirect has priority over all other events. If redirect_addr[1:0]==0, pc<=redirect_addr and:
  - REQ, no accept this cycle: stay in REQ; the new address is driven next cycle.
  - REQ, accept in the same cycle: the accepted request is wrong-path; go to WAIT with drop<=1.
  - WAIT with resp_valid in the same cycle: discard the response, go to REQ.
  - WAIT without resp_valid: drop<=1, go to REQ.
  - OUT: discard the held instruction; out_valid=0 next cycle; go to REQ, even if out_ready is high the same cycle. The IF/ID consumes that last instruction only if it is itself not flushed.
  - FAULT: clear misaligned_fault, go to REQ.
- Misaligned redirect (redirect_addr[1:0]!=0):
  - fault_pc<=redirect_addr, misaligned_fault<=1, go to FAULT.
  - Same drop rules as an aligned redirect.
  - No requests issue in FAULT; a response arriving while drop==1 clears drop.
  - Fault stays asserted until the next aligned redirect or reset.
- Reset mid-operation: returns to the reset state immediately. Any IMEM response after reset is ignored unless a request was accepted after reset.
- pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.

Test Plan:
- Release reset, IMEM ready=1, 1-cycle latency, out_ready=1:
  - Requests go to 0x0, 0x4, 0x8.
  - out_pc follows the same sequence with the matching instr.
  - out_valid pulses every 3 cycles.
- out_ready=0 for 5 cycles while out_valid=1 → out_pc and out_instr are held and no new imem request issues; then release.
- Redirect to 0x100 in the same cycle the request for 0x8 is accepted:
  - The 0x8 response is dropped.
  - The next request goes to 0x100, and out_pc=0x100.
- Redirect to 0x200 in WAIT, with the response delayed 3 cycles:
  - No new request issues until the stale response arrives.
  - Then a request to 0x200; no output for the stale word.
- Redirect to 0x102:
  - misaligned_fault=1 and fault_pc=0x102.
  - No requests issue.
  - A later redirect to 0x104 clears the fault and fetches 0x104.
- RESET_PC=32'hFFFF_FFFC → requests go to 0xFFFF_FFFC then 0x0. Asserting rst while in OUT clears out_valid immediately (asynchronously).
